// File: rtl/rf_pkg.sv
// Shared definitions for the register file with pending-write scoreboard:
// sweep FSM state encoding and the default datapath widths.
package rf_pkg;

  typedef enum logic {
    RF_SWEEP = 1'b0,
    RF_RUN   = 1'b1
  } rfState_t;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_READ = 2;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Sweep controller: after reset or a clear request it walks every register
// index once, one per cycle, so the storage array itself needs no reset.
module regfile_sweep_ctrl
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ClearReq,
  output logic              Busy,
  output logic              SweepWe,
  output logic [ADDR_W-1:0] SweepIdx
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  rfState_t        state;
  logic [ADDR_W:0] sweepPtr;

  // Sweep/run state machine; Busy is registered and falls on the edge that enters RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RF_SWEEP;
      sweepPtr <= '0;
      Busy     <= 1'b1;
    end else begin
      case (state)
        RF_SWEEP: begin
          sweepPtr <= sweepPtr + 1'b1;
          if (sweepPtr == LAST_PTR) begin
            state <= RF_RUN;
            Busy  <= 1'b0;
          end
        end
        RF_RUN: begin
          if (ClearReq) begin
            state    <= RF_SWEEP;
            sweepPtr <= '0;
            Busy     <= 1'b1;
          end
        end
        default: begin
          state    <= RF_SWEEP;
          sweepPtr <= '0;
          Busy     <= 1'b1;
        end
      endcase
    end
  end

  assign SweepWe  = (state == RF_SWEEP);
  assign SweepIdx = sweepPtr[ADDR_W-1:0];

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with optional write-to-read bypass,
// hardwired-zero register 0 and a per-register pending-write scoreboard.
// Decode reserves a destination, writeback commits it and clears the mark.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = RF_NUM_READ,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       ClearReq,
  output logic                       Busy,
  input  logic                       RegWre,
  input  logic [ADDR_W-1:0]          WriteReg,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic                       Reserve,
  input  logic [ADDR_W-1:0]          ReserveReg,
  input  logic [NUM_READ*ADDR_W-1:0] ReadReg,
  output logic [NUM_READ*DATA_W-1:0] ReadData,
  output logic [NUM_READ-1:0]        ReadValid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              sweepWe;
  logic [ADDR_W-1:0] sweepIdx;
  logic              writeOk;
  logic              reserveOk;
  logic [DATA_W-1:0] regArray [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pendingNext;

  regfile_sweep_ctrl #(
    .ADDR_W (ADDR_W)
  ) uSweepCtrl (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ClearReq (ClearReq),
    .Busy     (Busy),
    .SweepWe  (sweepWe),
    .SweepIdx (sweepIdx)
  );

  assign writeOk   = !Busy && RegWre  && !(ZERO_REG != 0 && WriteReg   == '0);
  assign reserveOk = !Busy && Reserve && !(ZERO_REG != 0 && ReserveReg == '0);

  // Storage: the sweep owns the write port while active, otherwise commits land here.
  always_ff @(posedge CLK) begin
    if (sweepWe) begin
      regArray[sweepIdx] <= '0;
    end else if (writeOk) begin
      regArray[WriteReg] <= WriteData;
    end
  end

  // Next scoreboard: a commit clears, a reservation sets (set wins), a clear request wipes all.
  always_comb begin
    pendingNext = pending;
    if (!Busy) begin
      if (writeOk) begin
        pendingNext[WriteReg] = 1'b0;
      end
      if (reserveOk) begin
        pendingNext[ReserveReg] = 1'b1;
      end
      if (ClearReq) begin
        pendingNext = '0;
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= '0;
    end else begin
      pending <= pendingNext;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : gReadPort
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] portData;
    logic              portValid;

    assign idx = ReadReg[k*ADDR_W +: ADDR_W];

    // Read mux: zero register, then same-cycle bypass, then array plus scoreboard.
    always_comb begin
      portData  = '0;
      portValid = 1'b0;
      if (!Busy) begin
        if (ZERO_REG != 0 && idx == '0) begin
          portData  = '0;
          portValid = 1'b1;
        end else if (BYPASS != 0 && RegWre && WriteReg == idx) begin
          portData  = WriteData;
          portValid = 1'b1;
        end else begin
          portData  = regArray[idx];
          portValid = !pending[idx];
        end
      end
    end

    assign ReadData[k*DATA_W +: DATA_W] = portData;
    assign ReadValid[k]                 = portValid;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus pushes expected read
// results from an abstract register model, a negedge monitor pops and compares.
module tb_regfile_scoreboard;

  logic        CLK;
  logic        RST_N;
  logic        ClearReq;
  logic        Busy;
  logic        RegWre;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Reserve;
  logic [4:0]  ReserveReg;
  logic [9:0]  ReadReg;
  logic [63:0] ReadData;
  logic [1:0]  ReadValid;

  typedef struct {
    int          tag;
    logic        busy;
    logic [31:0] data0;
    logic        valid0;
    logic [31:0] data1;
    logic        valid1;
  } expect_t;

  expect_t     expQ[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] modelRegs [32];
  bit          modelPend [32];
  int          sweepLeft;

  regfile_scoreboard #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_READ (2),
    .BYPASS   (1),
    .ZERO_REG (1)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ClearReq   (ClearReq),
    .Busy       (Busy),
    .RegWre     (RegWre),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .Reserve    (Reserve),
    .ReserveReg (ReserveReg),
    .ReadReg    (ReadReg),
    .ReadData   (ReadData),
    .ReadValid  (ReadValid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model of a freshly cleared file: everything zero, nothing pending, 32-cycle sweep ahead.
  task automatic modelClear();
    for (int i = 0; i < 32; i++) begin
      modelRegs[i] = '0;
      modelPend[i] = 1'b0;
    end
    sweepLeft = 32;
  endtask

  // Architectural read as seen this cycle, given the inputs currently on the bus.
  task automatic modelRead(input logic [4:0] idx, output logic [31:0] data, output logic valid);
    if (sweepLeft > 0) begin
      data = '0; valid = 1'b0;
    end else if (idx == 0) begin
      data = '0; valid = 1'b1;
    end else if (RegWre && WriteReg == idx) begin
      data = WriteData; valid = 1'b1;
    end else begin
      data = modelRegs[idx]; valid = !modelPend[idx];
    end
  endtask

  task automatic checkOne(input string name, input int tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s step=%0d got=%h expected=%h", name, tag, got, exp);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checkOne("busy",   e.tag, {31'd0, Busy},         {31'd0, e.busy});
    checkOne("data0",  e.tag, ReadData[31:0],        e.data0);
    checkOne("valid0", e.tag, {31'd0, ReadValid[0]}, {31'd0, e.valid0});
    checkOne("data1",  e.tag, ReadData[63:32],       e.data1);
    checkOne("valid1", e.tag, {31'd0, ReadValid[1]}, {31'd0, e.valid1});
  endtask

  // Monitor: every cycle with an outstanding expectation gets compared mid-cycle.
  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  int stepNo = 0;

  task automatic applyStimulus(input bit wre, input logic [4:0] wr, input logic [31:0] wd,
                               input bit res, input logic [4:0] rr,
                               input logic [4:0] r0, input logic [4:0] r1, input bit clr);
    expect_t e;
    RegWre = wre; WriteReg = wr; WriteData = wd;
    Reserve = res; ReserveReg = rr;
    ReadReg = {r1, r0}; ClearReq = clr;
    stepNo++;
    e.tag  = stepNo;
    e.busy = (sweepLeft > 0);
    modelRead(r0, e.data0, e.valid0);
    modelRead(r1, e.data1, e.valid1);
    expQ.push_back(e);
    @(posedge CLK);
    if (sweepLeft > 0) begin
      sweepLeft--;
    end else begin
      if (wre && wr != 0) begin
        modelRegs[wr] = wd;
        modelPend[wr] = 1'b0;
      end
      if (res && rr != 0) modelPend[rr] = 1'b1;
      if (clr) modelClear();
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] r0, input logic [4:0] r1);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, r0, r1, 0);
  endtask

  // Assert reset mid-cycle, check the forced-idle outputs, then release after two edges.
  task automatic doReset();
    expect_t e;
    RST_N = 1'b0;
    RegWre = 0; Reserve = 0; ClearReq = 0;
    #1;
    stepNo++;
    e.tag = stepNo; e.busy = 1'b1;
    e.data0 = '0; e.valid0 = 1'b0; e.data1 = '0; e.valid1 = 1'b0;
    expQ.push_back(e);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    modelClear();
  endtask

  initial begin
    RST_N = 1'b0; ClearReq = 0; RegWre = 0; WriteReg = 0; WriteData = 0;
    Reserve = 0; ReserveReg = 0; ReadReg = 0;
    modelClear();
    @(posedge CLK);
    doReset();

    // Sweep after reset: writes and reservations attempted meanwhile must vanish.
    for (int i = 0; i < 32; i++)
      applyStimulus(1, 5'(i), $urandom, 1, 5'(i), 5'(i), 5'd31 - 5'(i), 1);
    idle(1, 1, 31);

    // Bypass then array read.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 5, 6, 0);
    idle(1, 5, 0);

    // Reserve, pending, commit via bypass, then stays valid.
    applyStimulus(0, 0, 0, 1, 7, 7, 5, 0);
    idle(1, 7, 5);
    applyStimulus(1, 7, 32'h12, 0, 0, 7, 7, 0);
    idle(1, 7, 7);

    // Same-edge reserve and commit: reservation wins.
    applyStimulus(1, 9, 32'h55, 1, 9, 9, 0, 0);
    idle(1, 9, 9);

    // Register zero is immune.
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    idle(1, 0, 9);

    // Clear with a pending register and a same-cycle commit.
    applyStimulus(1, 3, 32'hA5, 0, 0, 3, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 3, 3, 0);
    applyStimulus(1, 3, 32'h77, 1, 4, 3, 4, 1);
    for (int i = 0; i < 32; i++)
      applyStimulus(1, 3, $urandom, 1, 3, 3, 4, 0);
    idle(2, 3, 4);

    // Reset in the middle of a sweep restarts the full sweep.
    applyStimulus(1, 8, 32'h88, 0, 0, 8, 0, 1);
    idle(10, 8, 0);
    doReset();
    idle(33, 8, 5);

    // Randomized traffic over a narrow index range to force collisions.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 11)), $urandom,
                    ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 11)),
                    5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                    ($urandom_range(0, 59) == 0));
    end

    @(negedge CLK);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queueDrain got=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
